logic_eval_pipe: RTL and testbench

LOGIC_EVAL_PIPE -- requirements
Module: logic_eval_pipe

---
 rtl/logic_eval_pipe.sv | 94 +++++++++
 tb/tb_logic_eval_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/logic_eval_pipe.sv
// logic_eval_pipe: two-stage valid/ready pipeline of per-channel bitwise 3-input logic functions.
// Define LOGIC_EVAL_CHG_CNT_EN to add the saturating chg_cnt output.
module logic_eval_pipe #(
    parameter int WIDTH = 8,
    parameter int CH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [CH*WIDTH-1:0] a,
    input  logic [CH*WIDTH-1:0] b,
    input  logic [CH*WIDTH-1:0] c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*WIDTH-1:0] y,
    output logic [CH-1:0]       d
`ifdef LOGIC_EVAL_CHG_CNT_EN
    ,
    output logic [15:0]         chg_cnt
`endif
);
    localparam int W = CH * WIDTH;

    logic          s1_v;
    logic [1:0]    s1_op;
    logic [W-1:0]  s1_a, s1_b, s1_c, y_nxt;
    logic [CH-1:0] d_nxt;
    logic          s2_load;

    always_comb
        y_nxt = s1_op == 2'b00 ? s1_a & s1_b & s1_c :
                s1_op == 2'b01 ? s1_a | s1_b | s1_c :
                s1_op == 2'b10 ? s1_a ^ s1_b ^ s1_c :
                                 (s1_a & s1_b) | (s1_b & s1_c) | (s1_a & s1_c);

    always_comb begin
        d_nxt = '0;
        for (int k = 0; k < CH; k++)
            d_nxt[k] = ^y_nxt[k*WIDTH +: WIDTH];
    end

    assign s2_load  = s1_v && (!out_valid || out_ready);
    // Equals "S1 empty or S1 drains this edge", so it doubles as the S1 load enable.
    assign in_ready = !(s1_v && out_valid && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_op <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_c  <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
                s1_c  <= c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            d         <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= y_nxt;
            d         <= d_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_EVAL_CHG_CNT_EN
    logic [W-1:0] last_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_y  <= '0;
            chg_cnt <= '0;
        end else if (out_valid && out_ready) begin
            last_y <= y;
            if (y != last_y && chg_cnt != 16'hFFFF)
                chg_cnt <= chg_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_logic_eval_pipe.sv
// tb_logic_eval_pipe: directed self-checking bench for logic_eval_pipe (WIDTH=8, CH=2).
module tb_logic_eval_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [15:0] a, b, c, y;
    logic [1:0]  d;
`ifdef LOGIC_EVAL_CHG_CNT_EN
    logic [15:0] chg_cnt;
`endif
    int passed = 0;
    int total  = 0;

    logic_eval_pipe #(.WIDTH(8), .CH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .d(d)
`ifdef LOGIC_EVAL_CHG_CNT_EN
        , .chg_cnt(chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [15:0] va, vb, vc);
        in_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        c = vc;
    endtask

    logic [15:0] exp_y [4] = '{16'h8080, 16'hFEFE, 16'h9696, 16'hE8E8};
    logic [1:0]  exp_d [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    logic [15:0] vals  [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    int idx;
    logic acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; a = '0; b = '0; c = '0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_d", d, 0);
`ifdef LOGIC_EVAL_CHG_CNT_EN
        chk("rst_chg_cnt", chg_cnt, 0);
`endif
        step(); step();
        rst_n = 1'b1;
        step();

        // MAJ beat: S1 after the transfer edge, result one edge later
        beat(2'b11, 16'h0F0F, 16'h00FF, 16'hF0F0);
        step();
        in_valid = 1'b0;
        a = 16'hFFFF; op = 2'b00;
        chk("maj_s1_only", out_valid, 0);
        step();
        chk("maj_valid", out_valid, 1);
        chk("maj_y", y, 16'h00FF);
        chk("maj_d", d, 2'b00);
        step();
        chk("maj_drained", out_valid, 0);
        chk("idle_y_held", y, 16'h00FF);

        // Four back-to-back ops
        for (int i = 0; i < 5; i++) begin
            if (i < 4) beat(i[1:0], 16'hAAAA, 16'hCCCC, 16'hF0F0);
            else in_valid = 1'b0;
            step();
            if (i > 0) begin
                chk($sformatf("b2b_valid%0d", i - 1), out_valid, 1);
                chk($sformatf("b2b_y%0d", i - 1), y, exp_y[i-1]);
                chk($sformatf("b2b_d%0d", i - 1), d, exp_d[i-1]);
            end
        end
        step();
        chk("b2b_empty", out_valid, 0);

        // Backpressure: 5 cycles of out_ready=0 with in_valid held high
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            beat(2'b01, vals[idx], 16'h0000, 16'h0000);
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
            if (cyc >= 1) chk($sformatf("stall_y%0d", cyc), y, vals[0]);
        end
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        step();
        chk("drain1_valid", out_valid, 1);
        chk("drain1_y", y, vals[1]);
        step();
        chk("drain_empty", out_valid, 0);

        // Mid-stream reset with two beats in flight
        beat(2'b01, 16'hDEAD, 16'h0000, 16'h0000);
        step();
        beat(2'b01, 16'hBEEF, 16'h0000, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_d", d, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_idle%0d", i), out_valid, 0);
        end

        // Parity per channel: first result after reset
        beat(2'b10, 16'h0100, 16'h0000, 16'h0000);
        step();
        in_valid = 1'b0;
        step();
        chk("par_valid", out_valid, 1);
        chk("par_y", y, 16'h0100);
        chk("par_d", d, 2'b10);
        step();
        chk("par_single", out_valid, 0);

`ifdef LOGIC_EVAL_CHG_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        beat(2'b01, 16'h0001, 16'h0000, 16'h0000);
        step();
        beat(2'b01, 16'h0001, 16'h0000, 16'h0000);
        step();
        beat(2'b01, 16'h0000, 16'h0000, 16'h0000);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("chg_cnt", chg_cnt, 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
